hamm_rx_ctrl: RTL and testbench



---
 rtl/hamm_rx_ctrl_if.sv | 34 +++
 rtl/hamm_rx_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hamm_rx_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hamm_rx_ctrl_if.sv
// Codeword-in / byte-out handshake bundle for the Hamming (8,4) receive controller.
// master = upstream/downstream environment side, slave = controller side.
interface hamm_rx_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_corr;
  logic       out_err;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_corr,
    input  out_err,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output out_valid,
    output out_data,
    output out_corr,
    output out_err,
    input  out_ready
  );
endinterface

// File: rtl/hamm_rx_ctrl.sv
// Hamming (8,4) SEC-DED receive controller: decodes codeword pairs into bytes, low nibble first.
// Latency: out_valid the cycle after the 2nd codeword is accepted; in_ready drops while a byte waits on out_ready.
module hamm_rx_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  hamm_rx_ctrl_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  localparam logic [3:0] COL_D0 = 4'b0111;
  localparam logic [3:0] COL_D1 = 4'b1011;
  localparam logic [3:0] COL_D2 = 4'b1101;
  localparam logic [3:0] COL_D3 = 4'b1110;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_data;
  logic             r_corr;
  logic             r_err;
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  logic       w_in_rdy;
  logic       w_out_vld;
  logic       w_accept;
  logic       w_take_lo;
  logic       w_take_hi;
  logic       w_release;
  logic [3:0] w_d;
  logic [3:0] w_par;
  logic [3:0] w_syn;
  logic [3:0] w_nib;
  logic       w_cw_corr;
  logic       w_cw_err;

  // ---------------------------------------------------------------
  // Combinational decode of the codeword currently on the bus
  // ---------------------------------------------------------------
  always_comb begin
    w_d   = bus.in_code[7:4];
    w_par = ({4{w_d[0]}} & COL_D0) ^
            ({4{w_d[1]}} & COL_D1) ^
            ({4{w_d[2]}} & COL_D2) ^
            ({4{w_d[3]}} & COL_D3);
    w_syn = w_par ^ bus.in_code[3:0];
  end

  always_comb begin
    w_nib     = w_d;
    w_cw_corr = 1'b0;
    w_cw_err  = 1'b0;
    case (w_syn)
      4'b0000: begin
        w_nib = w_d;
      end
      COL_D0: begin
        w_nib     = w_d ^ 4'b0001;
        w_cw_corr = 1'b1;
      end
      COL_D1: begin
        w_nib     = w_d ^ 4'b0010;
        w_cw_corr = 1'b1;
      end
      COL_D2: begin
        w_nib     = w_d ^ 4'b0100;
        w_cw_corr = 1'b1;
      end
      COL_D3: begin
        w_nib     = w_d ^ 4'b1000;
        w_cw_corr = 1'b1;
      end
      // single parity-bit hit: data nibble already correct
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        w_cw_corr = 1'b1;
      end
      default: begin
        w_cw_err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    w_out_vld   = 1'b0;
    w_take_lo   = 1'b0;
    w_take_hi   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_LO: begin
        w_in_rdy = 1'b1;
        if (bus.in_valid) begin
          w_take_lo   = 1'b1;
          w_state_nxt = S_HI;
        end
      end
      S_HI: begin
        w_in_rdy = 1'b1;
        if (bus.in_valid) begin
          w_take_hi   = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        w_out_vld = 1'b1;
        if (bus.out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_LO;
        end
      end
      default: begin
        w_state_nxt = S_LO;
      end
    endcase
  end

  assign w_accept = w_take_lo | w_take_hi;

  // ---------------------------------------------------------------
  // Byte assembly and sticky flags
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= 8'h00;
      r_corr <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_take_lo) begin
        r_data[3:0] <= w_nib;
        r_corr      <= w_cw_corr;
        r_err       <= w_cw_err;
      end else if (w_take_hi) begin
        r_data[7:4] <= w_nib;
        r_corr      <= r_corr | w_cw_corr;
        r_err       <= r_err  | w_cw_err;
      end else if (w_release) begin
        r_corr <= 1'b0;
        r_err  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Saturating statistics; a clear beats a same-cycle increment
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_accept && w_cw_corr && (r_corr_cnt != CNT_MAX)) begin
        r_corr_cnt <= r_corr_cnt + 1'b1;
      end
      if (w_accept && w_cw_err && (r_uncorr_cnt != CNT_MAX)) begin
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = w_out_vld;
  assign bus.out_data  = r_data;
  assign bus.out_corr  = r_corr;
  assign bus.out_err   = r_err;
  assign corr_cnt      = r_corr_cnt;
  assign uncorr_cnt    = r_uncorr_cnt;

endmodule

// File: tb/tb_hamm_rx_ctrl.sv
// Self-checking bench for hamm_rx_ctrl: scripted scenarios then random traffic against a
// nearest-codeword reference model.
module tb_hamm_rx_ctrl;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  hamm_rx_ctrl_if bus ();

  hamm_rx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int         m_half;
  logic [3:0] m_lo;
  logic       m_corr, m_err;
  logic [7:0] m_byte;
  int         m_ccnt, m_ucnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [3:0] col [4];
    logic [3:0] p;
    col[0] = 4'b0111; col[1] = 4'b1011; col[2] = 4'b1101; col[3] = 4'b1110;
    p = 4'b0000;
    for (int i = 0; i < 4; i++) if (d[i]) p = p ^ col[i];
    return {d, p};
  endfunction

  // {err, corr, nibble}: exact match, else distance-1 neighbour, else uncorrectable
  function automatic logic [5:0] ref_decode(input logic [7:0] c);
    for (int n = 0; n < 16; n++)
      if (enc(4'(n)) == c) return {2'b00, 4'(n)};
    for (int n = 0; n < 16; n++)
      if ($countones(enc(4'(n)) ^ c) == 1) return {2'b01, 4'(n)};
    return {2'b10, c[7:4]};
  endfunction

  task automatic model_accept(input logic [7:0] c, input logic clr);
    logic [5:0] r;
    r = ref_decode(c);
    if (clr) begin
      m_ccnt = 0; m_ucnt = 0;
    end else begin
      if (r[4] && m_ccnt < CMAX) m_ccnt++;
      if (r[5] && m_ucnt < CMAX) m_ucnt++;
    end
    if (m_half == 0) begin
      m_lo = r[3:0]; m_corr = r[4]; m_err = r[5]; m_half = 1;
    end else begin
      m_byte = {r[3:0], m_lo}; m_corr = m_corr | r[4]; m_err = m_err | r[5]; m_half = 0;
    end
  endtask

  task automatic model_reset();
    m_half = 0; m_lo = 4'h0; m_corr = 1'b0; m_err = 1'b0; m_byte = 8'h00; m_ccnt = 0; m_ucnt = 0;
  endtask

  // called at a negedge; returns at a negedge with in_valid low
  task automatic send_code(input logic [7:0] c, input logic clr);
    int n;
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      cnt_clr = clr;
      @(posedge clk);
      model_accept(c, clr);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_code  = 8'h00;
      cnt_clr      = 1'b0;
    end
  endtask

  task automatic recv_byte(input int hold, input int exp_lit);
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("out_data", 32'(bus.out_data), 32'(m_byte));
    chk("out_corr", 32'(bus.out_corr), 32'(m_corr));
    chk("out_err", 32'(bus.out_err), 32'(m_err));
    chk("corr_cnt", 32'(corr_cnt), 32'(m_ccnt));
    chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_ucnt));
    if (exp_lit >= 0) chk("plan_byte", 32'(bus.out_data), 32'(exp_lit));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", 32'(bus.out_data), 32'(m_byte));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    m_corr = 1'b0; m_err = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int hold, input int exp_lit);
    send_code(a, 1'b0);
    send_code(b, 1'b0);
    recv_byte(hold, exp_lit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c0, c1;
    int b1, kind;
    reset         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = 8'h00;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_flags", 32'({bus.out_corr, bus.out_err}), 32'd0);
    chk("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    send_pair(8'h17, 8'h2B, 0, 8'h21);   // clean
    send_pair(8'h57, 8'h2B, 0, 8'h21);   // data-bit error
    send_pair(8'h2A, 8'h17, 0, 8'h12);   // parity-bit error
    send_pair(8'h27, 8'h00, 0, 8'h02);   // double error, raw nibble
    send_pair(8'hFF, 8'hFF, 5, 8'hFF);   // backpressure

    // saturation: corrected codewords push corr_cnt to its ceiling
    send_pair(8'h57, 8'h57, 0, 8'h11);
    send_pair(8'h57, 8'h57, 0, 8'h11);
    chk("corr_sat", 32'(corr_cnt), 32'(CMAX));
    send_code(8'h57, 1'b1);
    chk("clr_wins", 32'(corr_cnt), 32'd0);
    send_code(8'h17, 1'b0);
    recv_byte(0, 8'h11);

    // asynchronous reset while a half byte is held
    send_code(8'h17, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    chk("amid_valid", 32'(bus.out_valid), 32'd0);
    chk("amid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("amid_data", 32'(bus.out_data), 32'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_pair(8'h3C, 8'h4D, 0, 8'h43);

    // random traffic
    for (int t = 0; t < 150; t++) begin
      for (int h = 0; h < 2; h++) begin
        c0   = enc(4'($urandom_range(0, 15)));
        kind = $urandom_range(0, 2);
        b1   = $urandom_range(0, 7);
        if (kind >= 1) c0 = c0 ^ (8'h01 << b1);
        if (kind == 2) c0 = c0 ^ (8'h01 << ((b1 + $urandom_range(1, 7)) % 8));
        if (h == 0) c1 = c0;
        send_code(c0, ($urandom_range(0, 15) == 0));
      end
      recv_byte($urandom_range(0, 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
